// File: rtl/pulse_rate_decoder_pkg.sv
// Shared speed codes, FSM state encoding and the code-to-interval map used by
// the pulse rate decoder.
package pulse_rate_decoder_pkg;

    localparam logic [1:0] SPD_FAST = 2'b00;
    localparam logic [1:0] SPD_1HZ  = 2'b01;
    localparam logic [1:0] SPD_HALF = 2'b10;
    localparam logic [1:0] SPD_QTR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        CAND   = 2'd2,
        LOCKED = 2'd3
    } state_e;

    // Pulse interval, in clock cycles, produced by a divider running at 'code'.
    function automatic int unsigned spd_interval(input logic [1:0] code,
                                                 input int unsigned base);
        case (code)
            SPD_FAST: return 1;
            SPD_1HZ:  return base;
            SPD_HALF: return 2 * base;
            default:  return 4 * base;
        endcase
    endfunction

endpackage

// File: rtl/pulse_rate_decoder_interval.sv
// Interval timer: counts cycles since the last pulse and flags a timeout once
// the slowest legal interval has elapsed without a new pulse.
module interval_timer #(
    parameter int unsigned BASE_TICKS = 500,
    parameter int unsigned CNT_W      = 11
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pulse_i,
    input  logic             run_i,
    output logic [CNT_W-1:0] interval_o,
    output logic             timeout_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(4 * BASE_TICKS);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A pulse outranks the timeout: an on-time slowest-rate pulse is legal.
    assign timeout_o  = run_i && !pulse_i && (cnt_q == LIMIT);
    assign interval_o = cnt_q;

    // Restart on pulse, clear on timeout, count while armed, hold in IDLE.
    always_comb begin
        cnt_d = cnt_q;
        if (pulse_i)        cnt_d = CNT_W'(1);
        else if (timeout_o) cnt_d = '0;
        else if (run_i)     cnt_d = cnt_q + 1'b1;
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/pulse_rate_decoder.sv
// Pulse rate decoder: classifies the spacing of an enable pulse train back
// into its 2-bit speed code and reports lock once two consecutive intervals
// agree.
module pulse_rate_decoder
    import pulse_rate_decoder_pkg::*;
#(
    parameter int unsigned BASE_TICKS = 500,
    parameter int unsigned CNT_W      = 11
) (
    input  logic       ClockIn,
    input  logic       Reset,
    input  logic       PulseIn,
    output logic [1:0] SpeedOut,
    output logic       Valid,
    output logic       Error
);

    state_e           state_q, state_d;
    logic [1:0]       cand_q, cand_d;
    logic [1:0]       spd_q, spd_d;
    logic             vld_q, vld_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] interval;
    logic             timeout;
    logic             cls_ok;
    logic [1:0]       cls_code;

    interval_timer #(
        .BASE_TICKS (BASE_TICKS),
        .CNT_W      (CNT_W)
    ) u_timer (
        .clk_i      (ClockIn),
        .rst_i      (Reset),
        .pulse_i    (PulseIn),
        .run_i      (state_q != IDLE),
        .interval_o (interval),
        .timeout_o  (timeout)
    );

    // Map the measured interval onto one of the four legal speed codes.
    always_comb begin
        cls_ok   = 1'b0;
        cls_code = SPD_FAST;
        for (int c = 0; c < 4; c++) begin
            if (interval == CNT_W'(spd_interval(2'(c), BASE_TICKS))) begin
                cls_ok   = 1'b1;
                cls_code = 2'(c);
            end
        end
    end

    // Lock FSM: two matching intervals in a row are required to lock.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        spd_d   = spd_q;
        vld_d   = vld_q;
        err_d   = 1'b0;
        if (PulseIn) begin
            case (state_q)
                IDLE: state_d = FIRST;
                FIRST: begin
                    if (cls_ok) begin
                        state_d = CAND;
                        cand_d  = cls_code;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
                CAND: begin
                    if (!cls_ok) begin
                        state_d = FIRST;
                        err_d   = 1'b1;
                    end else if (cls_code == cand_q) begin
                        state_d = LOCKED;
                        spd_d   = cand_q;
                        vld_d   = 1'b1;
                    end else begin
                        cand_d  = cls_code;
                    end
                end
                default: begin
                    if (!cls_ok) begin
                        state_d = FIRST;
                        vld_d   = 1'b0;
                        err_d   = 1'b1;
                    end else if (cls_code != spd_q) begin
                        state_d = CAND;
                        cand_d  = cls_code;
                        vld_d   = 1'b0;
                    end
                end
            endcase
        end else if (timeout) begin
            state_d = IDLE;
            vld_d   = 1'b0;
            err_d   = 1'b1;
        end
    end

    // State and output registers; reset wins over any simultaneous pulse.
    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            state_q <= IDLE;
            cand_q  <= SPD_FAST;
            spd_q   <= SPD_FAST;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            spd_q   <= spd_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    assign SpeedOut = spd_q;
    assign Valid    = vld_q;
    assign Error    = err_q;

endmodule

// File: tb/tb_pulse_rate_decoder.sv
// Directed bench for pulse_rate_decoder with BASE_TICKS=500.
module tb_pulse_rate_decoder;

    logic       ClockIn = 1'b0;
    logic       Reset   = 1'b1;
    logic       PulseIn = 1'b0;
    logic [1:0] SpeedOut;
    logic       Valid;
    logic       Error;

    int vectors     = 0;
    int miscompares = 0;
    int err_seen    = 0;

    pulse_rate_decoder #(.BASE_TICKS(500), .CNT_W(11)) dut (
        .ClockIn  (ClockIn),
        .Reset    (Reset),
        .PulseIn  (PulseIn),
        .SpeedOut (SpeedOut),
        .Valid    (Valid),
        .Error    (Error)
    );

    always #5 ClockIn = ~ClockIn;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock with PulseIn=p; outputs are sampled 1 time unit after the edge.
    task automatic cyc(input logic p);
        PulseIn = p;
        @(posedge ClockIn);
        #1;
        if (Error === 1'b1) err_seen++;
    endtask

    // Pulse arriving n cycles after the previous one.
    task automatic gap(input int n);
        for (int i = 0; i < n - 1; i++) cyc(1'b0);
        cyc(1'b1);
    endtask

    initial begin
        @(posedge ClockIn); #1;
        cyc(1'b0);
        cyc(1'b1);
        chk("rst_valid", Valid, 0);
        chk("rst_speed", SpeedOut, 0);
        chk("rst_error", Error, 0);
        Reset = 1'b0;

        // PulseIn held high: lock on code 00 after the third pulse.
        err_seen = 0;
        cyc(1'b1);
        cyc(1'b1);
        chk("fast_not_yet", Valid, 0);
        cyc(1'b1);
        chk("fast_valid", Valid, 1);
        chk("fast_speed", SpeedOut, 0);
        cyc(1'b1);
        cyc(1'b1);
        chk("fast_hold", Valid, 1);
        chk("fast_noerr", err_seen, 0);

        // 500-cycle spacing: leave 00, lock on 01, stay locked for 10 pulses.
        gap(500);
        chk("1hz_cand_valid", Valid, 0);
        gap(500);
        chk("1hz_valid", Valid, 1);
        chk("1hz_speed", SpeedOut, 1);
        err_seen = 0;
        for (int k = 0; k < 10; k++) gap(500);
        chk("1hz_hold_valid", Valid, 1);
        chk("1hz_hold_speed", SpeedOut, 1);
        chk("1hz_hold_noerr", err_seen, 0);

        // Switch to 2000-cycle spacing: drop on the first, relock on 11.
        gap(2000);
        chk("qtr_drop_valid", Valid, 0);
        chk("qtr_drop_speed_held", SpeedOut, 1);
        chk("qtr_edge_noerr", Error, 0);
        gap(2000);
        chk("qtr_valid", Valid, 1);
        chk("qtr_speed", SpeedOut, 3);
        chk("qtr_noerr", err_seen, 0);

        // Lock at 10, then starve the input until the timeout fires.
        gap(1000);
        chk("half_cand_valid", Valid, 0);
        gap(1000);
        chk("half_valid", Valid, 1);
        chk("half_speed", SpeedOut, 2);
        for (int i = 0; i < 1999; i++) cyc(1'b0);
        chk("to_before_err", Error, 0);
        chk("to_before_valid", Valid, 1);
        cyc(1'b0);
        chk("to_err", Error, 1);
        chk("to_valid", Valid, 0);
        chk("to_speed_held", SpeedOut, 2);
        err_seen = 0;
        for (int i = 0; i < 100; i++) cyc(1'b0);
        chk("idle_noerr", err_seen, 0);

        // 500 then 700: error on the bad interval; 500,500 relocks on 01.
        cyc(1'b1);
        gap(500);
        chk("bad_cand_valid", Valid, 0);
        gap(700);
        chk("bad_err", Error, 1);
        chk("bad_valid", Valid, 0);
        err_seen = 0;
        gap(500);
        chk("bad_recand_valid", Valid, 0);
        gap(500);
        chk("bad_relock_valid", Valid, 1);
        chk("bad_relock_speed", SpeedOut, 1);
        chk("bad_relock_noerr", err_seen, 0);

        // Reset coincident with a pulse while locked.
        Reset = 1'b1;
        cyc(1'b1);
        Reset = 1'b0;
        chk("mrst_valid", Valid, 0);
        chk("mrst_speed", SpeedOut, 0);
        chk("mrst_error", Error, 0);
        cyc(1'b1);
        gap(500);
        chk("mrst_cand_valid", Valid, 0);
        gap(500);
        chk("mrst_relock_valid", Valid, 1);
        chk("mrst_relock_speed", SpeedOut, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pulse_rate_decoder.md
Name: pulse_rate_decoder

Overview:
Receiver-side counterpart to the adjustable rate divider. It watches a stream of single-cycle enable pulses and measures the interval between successive pulses. It classifies that interval back into the 2-bit Speed code that produced it (00 = every cycle, 01 = 1 Hz, 10 = 0.5 Hz, 11 = 0.25 Hz). Used on the 500 Hz simulation clock and, with BASE_TICKS scaled, at 50 MHz on the board to confirm the divider/counter chain.

Parameters:
BASE_TICKS, 500, clock cycles per 1 Hz interval (50_000_000 on FPGA)
CNT_W, 11, interval counter width; must satisfy 4*BASE_TICKS < 2**CNT_W

Ports:
ClockIn  input  1  system clock, all logic on posedge
Reset  input  1  synchronous, active-high; clears all state and outputs
PulseIn  input  1  enable pulse stream, synchronous to ClockIn, one cycle per event
SpeedOut  output  2  decoded Speed code, valid when Valid=1
Valid  output  1  high while locked to a consistent rate
Error  output  1  one-cycle pulse on an unclassifiable interval or timeout

Behaviour:
- Interface: one clock (ClockIn); Reset is synchronous and active-high. On Reset=1 at a posedge:
  - state=IDLE, Cnt=0, Cand=00;
  - SpeedOut=00, Valid=0, Error=0.
- Interval counter Cnt (CNT_W bits):
  - PulseIn=1 -> Cnt<=1;
  - else, in any state other than IDLE -> Cnt<=Cnt+1;
  - in IDLE with no pulse, Cnt holds.
- Interval at a pulse = Cnt value in that cycle (cycles since previous pulse).
- Classification of an interval I:
  - 1 -> 00;
  - BASE_TICKS -> 01;
  - 2*BASE_TICKS -> 10;
  - 4*BASE_TICKS -> 11;
  - any other value -> invalid.
- States: IDLE, FIRST (one pulse seen), CAND (one valid interval, candidate code in Cand), LOCKED.
- Transitions (evaluated on PulseIn=1):
  - IDLE -> FIRST.
  - FIRST: valid I -> CAND with Cand=code; invalid -> FIRST, Error pulse.
  - CAND: code==Cand -> LOCKED, SpeedOut<=Cand, Valid<=1.
  - CAND: different valid code -> CAND with Cand=new code.
  - CAND: invalid -> FIRST, Error pulse.
  - LOCKED: code==SpeedOut -> stay, outputs unchanged.
  - LOCKED: different valid code -> CAND with Cand=new code, Valid<=0.
  - LOCKED: invalid -> FIRST, Valid<=0, Error pulse.
- Timeout:
  - Condition: in FIRST, CAND or LOCKED, PulseIn=0 and Cnt==4*BASE_TICKS.
  - Response: next state IDLE, Valid<=0, Error pulse, Cnt<=0.
  - A pulse arriving in the same cycle that Cnt==4*BASE_TICKS takes priority. It is classified as code 11; no timeout.
- Latency: Valid and SpeedOut update on the posedge that samples the third pulse of a consistent train, i.e. they are visible in the cycle after that pulse.
- SpeedOut holds its last locked value while Valid=0; consumers must qualify it with Valid.
- Error is registered, high for exactly one cycle per event, never asserted in IDLE.
- Reset mid-operation (any state, any Cnt) overrides a simultaneous PulseIn; the block returns to IDLE immediately.
- No saturation is needed: the timeout fires before Cnt exceeds 4*BASE_TICKS.

Decomposition:
- Shared package holds:
  - speed-code constants SPD_FAST=00, SPD_1HZ=01, SPD_HALF=10, SPD_QTR=11;
  - state encoding IDLE/FIRST/CAND/LOCKED;
  - a function mapping a Speed code to its interval in BASE_TICKS units (1 -> 1 cycle, then 1, 2, 4 multiples).
- One natural sub-module: interval_timer. It contains Cnt, the restart-on-pulse logic and the timeout compare, and outputs Interval plus a Timeout strobe. The FSM and classifier stay in pulse_rate_decoder.

Test Plan:
- Reset, then PulseIn held high for 5 cycles -> Valid=1, SpeedOut=00 in the cycle after the 3rd pulse; Error never asserted.
- Pulses every 500 cycles (BASE_TICKS=500) -> after the 3rd pulse Valid=1, SpeedOut=01; continuing 10 more pulses keeps Valid=1, Error=0.
- Locked at 01, then intervals switch to 2000 -> Valid drops on the first 2000 interval, re-locks with SpeedOut=11 after the second 2000 interval.
- Locked at 10, then no pulse for 2000 cycles -> Valid=0, single Error pulse when Cnt hits 2000, state IDLE; a pulse arriving exactly at interval 2000 instead yields no Error.
- Intervals 500, 700 -> Error pulse on the 700 interval, Valid stays 0; a following 500, 500 pair locks to 01.
- Locked at 01, assert Reset for one cycle coincident with a pulse -> next cycle Valid=0, SpeedOut=00, Error=0; two more 500-cycle intervals are needed to re-lock.
